// File: rtl/key_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// key_debounce_ctrl
//
// Conditions the active-low board push-buttons for the LED running light.
// Each raw key passes through a two-flop synchroniser and a per-key debounce
// counter. The clean result is presented as a level and as one-cycle
// press/release pulses. Keys 0..3 then drive the run/pause, direction and
// speed registers that the LED sequencer consumes.
//
// Ports
//   clk          in   system clock (50 MHz board clock)
//   rst_n        in   asynchronous active-low reset
//   key_n        in   raw key pins, active-low, asynchronous to clk
//   key_level    out  debounced key state, 1 = pressed
//   key_press    out  one-cycle pulse when a press is accepted
//   key_release  out  one-cycle pulse when a release is accepted
//   run_en       out  1 = sequencer advances, 0 = paused
//   dir          out  0 = shift up, 1 = shift down
//   speed        out  step-rate select, 0 = slowest .. 3 = fastest
//
// Key map (acts on the cycle after the press pulse):
//   key0 toggles run_en, key1 toggles dir, key2 steps speed (3 wraps to 0),
//   key3 restores run_en=1/dir=0/speed=0 and overrides the others.
// ---------------------------------------------------------------------------
module key_debounce_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                run_en,
    output logic                dir,
    output logic [1:0]          speed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchroniser; resets to the released (high) pin level.
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Per-key debounce. The pulses are registered alongside the level so that
    // a pulse is high exactly on the first cycle the new level is visible.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        logic             sample;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;

        assign sample = ~sync2_q[gi];

        always_comb begin
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sample == level_q) begin
                // Agreement (including any bounce back) restarts the count.
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                level_d   = sample;
                cnt_d     = '0;
                press_d   = sample;
                release_d = ~sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign key_level[gi]   = level_q;
        assign key_press[gi]   = press_q;
        assign key_release[gi] = release_q;
    end

    // Control registers, driven from the registered press pulses of keys 0..3.
    logic       run_en_q;
    logic       run_en_d;
    logic       dir_q;
    logic       dir_d;
    logic [1:0] speed_q;
    logic [1:0] speed_d;

    always_comb begin
        run_en_d = run_en_q;
        dir_d    = dir_q;
        speed_d  = speed_q;
        if (key_press[3]) begin
            // Soft default wins over anything pressed in the same cycle.
            run_en_d = 1'b1;
            dir_d    = 1'b0;
            speed_d  = 2'd0;
        end else begin
            if (key_press[0]) run_en_d = ~run_en_q;
            if (key_press[1]) dir_d    = ~dir_q;
            if (key_press[2]) speed_d  = speed_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en_q <= 1'b1;
            dir_q    <= 1'b0;
            speed_q  <= 2'd0;
        end else begin
            run_en_q <= run_en_d;
            dir_q    <= dir_d;
            speed_q  <= speed_d;
        end
    end

    assign run_en = run_en_q;
    assign dir    = dir_q;
    assign speed  = speed_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_ctrl
//
// Directed bench for key_debounce_ctrl with DEBOUNCE_CYCLES = 8, so a clean
// key edge shows up on key_level 10 clock edges later. Every expected pulse
// (press/release vector and the cycle it must appear on) is queued when the
// key stimulus is driven; a monitor pops and compares on each observed pulse
// and flags any expected pulse that never arrives.
// ---------------------------------------------------------------------------
module tb_key_debounce_ctrl;

    localparam int NK  = 4;
    localparam int DB  = 8;
    localparam int LAT = DB + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          run_en;
    logic          dir;
    logic [1:0]    speed;

    key_debounce_ctrl #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .run_en      (run_en),
        .dir         (dir),
        .speed       (speed)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_fail  = 0;

    typedef struct {
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        int            at;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [NK-1:0] p, input logic [NK-1:0] r, input int at);
        ev_t e;
        e.press = p;
        e.rel   = r;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        ev_t e;
        if ((key_press | key_release) != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {24'd0, key_press, key_release}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_vec", {24'd0, key_press, key_release}, {24'd0, e.press, e.rel});
                check("pulse_cycle", cyc, e.at);
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
            e = exp_q.pop_front();
            check("missed_pulse", {24'd0, 8'd0}, {24'd0, e.press, e.rel});
        end
    end

    // Press the keys in m together, then release them; control state is
    // checked once after the press takes effect and again after the release.
    task automatic tap(input logic [NK-1:0] m, input logic er, input logic ed, input logic [1:0] es);
        key_n = key_n & ~m;
        push(m, '0, cyc + LAT);
        tick(LAT + 1);
        check("tap_run_en", {31'd0, run_en}, {31'd0, er});
        check("tap_dir",    {31'd0, dir},    {31'd0, ed});
        check("tap_speed",  {30'd0, speed},  {30'd0, es});
        key_n = key_n | m;
        push('0, m, cyc + LAT);
        tick(LAT + 2);
        check("rel_run_en", {31'd0, run_en}, {31'd0, er});
        check("rel_dir",    {31'd0, dir},    {31'd0, ed});
        check("rel_speed",  {30'd0, speed},  {30'd0, es});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset with every key held down.
        rst_n = 1'b0;
        key_n = '0;
        tick(3);
        check("rst_level",   {28'd0, key_level},   32'd0);
        check("rst_press",   {28'd0, key_press},   32'd0);
        check("rst_release", {28'd0, key_release}, 32'd0);
        check("rst_run_en",  {31'd0, run_en},      32'd1);
        check("rst_dir",     {31'd0, dir},         32'd0);
        check("rst_speed",   {30'd0, speed},       32'd0);
        tick(12);
        check("rst_level_held", {28'd0, key_level}, 32'd0);
        key_n = '1;
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_level", {28'd0, key_level}, 32'd0);

        // Clean press on key0, exact latency, then hold without repeat.
        c = cyc;
        key_n[0] = 1'b0;
        push(4'b0001, '0, c + LAT);
        tick(LAT - 1);
        check("k0_level_early", {31'd0, key_level[0]}, 32'd0);
        tick(1);
        check("k0_level",       {31'd0, key_level[0]}, 32'd1);
        check("k0_press",       {28'd0, key_press},    32'd1);
        tick(1);
        check("k0_press_gone",  {28'd0, key_press},    32'd0);
        check("k0_run_en",      {31'd0, run_en},       32'd0);
        tick(20);
        check("k0_hold_run_en", {31'd0, run_en},       32'd0);
        key_n[0] = 1'b1;
        push('0, 4'b0001, cyc + LAT);
        tick(LAT + 2);
        check("k0_rel_level",   {31'd0, key_level[0]}, 32'd0);
        check("k0_rel_run_en",  {31'd0, run_en},       32'd0);

        // Bounce on key1: toggles every 3 cycles, then settles pressed.
        for (int k = 0; k < 10; k++) begin
            key_n[1] = k[0];
            tick(3);
        end
        check("k1_bounce_level", {31'd0, key_level[1]}, 32'd0);
        c = cyc;
        key_n[1] = 1'b0;
        push(4'b0010, '0, c + LAT);
        tick(LAT);
        check("k1_level", {31'd0, key_level[1]}, 32'd1);
        tick(1);
        check("k1_dir",   {31'd0, dir},          32'd1);
        key_n[1] = 1'b1;
        push('0, 4'b0010, cyc + LAT);
        tick(LAT + 2);

        // Speed steps and wraps.
        tap(4'b0100, 1'b0, 1'b1, 2'd1);
        tap(4'b0100, 1'b0, 1'b1, 2'd2);
        tap(4'b0100, 1'b0, 1'b1, 2'd3);
        tap(4'b0100, 1'b0, 1'b1, 2'd0);

        // Set up run_en=1, dir=1, speed=2, then key0+key3 together.
        tap(4'b0001, 1'b1, 1'b1, 2'd0);
        tap(4'b0100, 1'b1, 1'b1, 2'd1);
        tap(4'b0100, 1'b1, 1'b1, 2'd2);
        tap(4'b1001, 1'b1, 1'b0, 2'd0);

        // Make dir non-default so the reset below is visible.
        tap(4'b0010, 1'b1, 1'b1, 2'd0);

        // Reset in the middle of a key2 debounce, key kept held.
        key_n[2] = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_dir",   {31'd0, dir},       32'd0);
        check("mid_rst_run",   {31'd0, run_en},    32'd1);
        check("mid_rst_level", {28'd0, key_level}, 32'd0);
        rst_n = 1'b1;
        c = cyc;
        push(4'b0100, '0, c + LAT);
        tick(LAT - 1);
        check("k2_level_early", {31'd0, key_level[2]}, 32'd0);
        tick(1);
        check("k2_level",       {31'd0, key_level[2]}, 32'd1);
        tick(1);
        check("k2_speed",       {30'd0, speed},        32'd1);
        key_n[2] = 1'b1;
        push('0, 4'b0100, cyc + LAT);
        tick(LAT + 3);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
